// File: rtl/hazard_unit.sv
// hazard_unit: stall / flush / forward-select controller for the five-stage
// RISC-V pipeline. Control outputs are combinational from the current-cycle
// stage fields. A post-reset window forces the front end to flush for
// RESET_FLUSH cycles. Saturating counters record cycles, load-use stalls,
// redirect flushes and forwarding activity.
module hazard_unit #(
    parameter int CNT_W       = 32,
    parameter int RESET_FLUSH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             init_busy,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    // Init counter just wide enough to hold RESET_FLUSH; one bit minimum so a
    // disabled window still yields a legal (constant zero) register.
    localparam int INIT_W = (RESET_FLUSH > 0) ? $clog2(RESET_FLUSH + 1) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(RESET_FLUSH);

    // Forward-select encodings for the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ResultSrcE encoding that marks a load in EX.
    localparam logic [1:0] RES_LOAD = 2'b01;

    logic [INIT_W-1:0] initCnt_r;
    logic              initBusy_s;
    logic              lwStall_s;
    logic [1:0]        fwdA_s;
    logic [1:0]        fwdB_s;
    logic              stallInc_s;
    logic              flushInc_s;
    logic              fwdInc_s;
    logic [CNT_W-1:0]  cycCnt_r;
    logic [CNT_W-1:0]  stallCnt_r;
    logic [CNT_W-1:0]  flushCnt_r;
    logic [CNT_W-1:0]  fwdCnt_r;

    // Select the newest producer of a source register. MEM holds the younger
    // result, so it is checked before WB. x0 is never forwarded since it is
    // hardwired to zero regardless of what an older instruction targeted.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdMem,
        input logic       wrMem,
        input logic [4:0] rdWb,
        input logic       wrWb
    );
        logic [1:0] sel;
        if ((rs != 5'd0) && (rs == rdMem) && wrMem) begin
            sel = FWD_MEM;
        end else if ((rs != 5'd0) && (rs == rdWb) && wrWb) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] satInc(
        input logic [CNT_W-1:0] value,
        input logic             en
    );
        logic [CNT_W-1:0] nextVal;
        if (en && (value != {CNT_W{1'b1}})) begin
            nextVal = value + CNT_W'(1);
        end else begin
            nextVal = value;
        end
        return nextVal;
    endfunction

    // Post-reset window counter: reloads on reset, counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            initCnt_r <= INIT_LOAD;
        end else if (initCnt_r != '0) begin
            initCnt_r <= initCnt_r - INIT_W'(1);
        end else begin
            initCnt_r <= initCnt_r;
        end
    end

    assign initBusy_s = (initCnt_r != '0);
    assign init_busy  = initBusy_s;

    // Raw hazard detection from the current stage fields.
    always_comb begin
        fwdA_s    = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwdB_s    = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        lwStall_s = 1'b0;
        if ((ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
            ((RdE == Rs1D) || (RdE == Rs2D))) begin
            lwStall_s = 1'b1;
        end else begin
            lwStall_s = 1'b0;
        end
    end

    // Pipeline control. During the init window the front end is held in a
    // flushed state and nothing is forwarded. Outside it, a redirect and a
    // load-use stall may coincide; the register clear dominates the hold
    // downstream, so both are simply driven.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (initBusy_s) begin
            StallF    = 1'b1;
            StallD    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            StallF    = lwStall_s;
            StallD    = lwStall_s;
            FlushD    = PCSrcE;
            FlushE    = lwStall_s | PCSrcE;
            ForwardAE = fwdA_s;
            ForwardBE = fwdB_s;
        end
    end

    // Event qualifiers: only normal-operation cycles are attributed.
    always_comb begin
        stallInc_s = lwStall_s & ~initBusy_s;
        flushInc_s = PCSrcE & ~initBusy_s;
        fwdInc_s   = ((ForwardAE != FWD_RF) | (ForwardBE != FWD_RF)) & ~initBusy_s;
    end

    // Cycle counter; runs through the init window as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycCnt_r <= '0;
        end else if (cnt_clr) begin
            cycCnt_r <= '0;
        end else begin
            cycCnt_r <= satInc(cycCnt_r, 1'b1);
        end
    end

    // Load-use stall counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_r <= '0;
        end else if (cnt_clr) begin
            stallCnt_r <= '0;
        end else begin
            stallCnt_r <= satInc(stallCnt_r, stallInc_s);
        end
    end

    // Redirect flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushCnt_r <= '0;
        end else if (cnt_clr) begin
            flushCnt_r <= '0;
        end else begin
            flushCnt_r <= satInc(flushCnt_r, flushInc_s);
        end
    end

    // Forwarding-activity counter (either operand forwarded counts once).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdCnt_r <= '0;
        end else if (cnt_clr) begin
            fwdCnt_r <= '0;
        end else begin
            fwdCnt_r <= satInc(fwdCnt_r, fwdInc_s);
        end
    end

    assign cyc_cnt   = cycCnt_r;
    assign stall_cnt = stallCnt_r;
    assign flush_cnt = flushCnt_r;
    assign fwd_cnt   = fwdCnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Three instances share the stimulus:
// the default build (window of 2, 32-bit counters), one with the window
// disabled, and one with 4-bit counters to reach saturation quickly.
`timescale 1ns/1ps
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, cnt_clr;

    logic        StallF_m, StallD_m, FlushD_m, FlushE_m, init_busy_m;
    logic [1:0]  ForwardAE_m, ForwardBE_m;
    logic [31:0] cyc_cnt_m, stall_cnt_m, flush_cnt_m, fwd_cnt_m;

    logic        StallF_n, StallD_n, FlushD_n, FlushE_n, init_busy_n;
    logic [1:0]  ForwardAE_n, ForwardBE_n;
    logic [31:0] cyc_cnt_n, stall_cnt_n, flush_cnt_n, fwd_cnt_n;

    logic        StallF_s, StallD_s, FlushD_s, FlushE_s, init_busy_s;
    logic [1:0]  ForwardAE_s, ForwardBE_s;
    logic [3:0]  cyc_cnt_s, stall_cnt_s, flush_cnt_s, fwd_cnt_s;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(32), .RESET_FLUSH(2)) dutMain (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
        .StallF(StallF_m), .StallD(StallD_m), .FlushD(FlushD_m), .FlushE(FlushE_m),
        .ForwardAE(ForwardAE_m), .ForwardBE(ForwardBE_m), .init_busy(init_busy_m),
        .cyc_cnt(cyc_cnt_m), .stall_cnt(stall_cnt_m), .flush_cnt(flush_cnt_m), .fwd_cnt(fwd_cnt_m)
    );

    hazard_unit #(.CNT_W(32), .RESET_FLUSH(0)) dutNoWin (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
        .StallF(StallF_n), .StallD(StallD_n), .FlushD(FlushD_n), .FlushE(FlushE_n),
        .ForwardAE(ForwardAE_n), .ForwardBE(ForwardBE_n), .init_busy(init_busy_n),
        .cyc_cnt(cyc_cnt_n), .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n), .fwd_cnt(fwd_cnt_n)
    );

    hazard_unit #(.CNT_W(4), .RESET_FLUSH(2)) dutSat (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
        .StallF(StallF_s), .StallD(StallD_s), .FlushD(FlushD_s), .FlushE(FlushE_s),
        .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s), .init_busy(init_busy_s),
        .cyc_cnt(cyc_cnt_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s), .fwd_cnt(fwd_cnt_s)
    );

    task automatic setIdle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0; cnt_clr = 1'b0;
    endtask

    // Idle inputs, one clearing edge, returns at the following negedge.
    task automatic clearCounters();
        @(negedge clk);
        setIdle();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setIdle();
        #1;
        nChecks++; if (init_busy_m !== 1'b1) begin nFails++; $display("FAIL rst_busy: got %b want 1", init_busy_m); end
        nChecks++; if ({StallF_m, StallD_m, FlushD_m, FlushE_m} !== 4'b1011) begin nFails++; $display("FAIL rst_ctrl: got %b want 1011", {StallF_m, StallD_m, FlushD_m, FlushE_m}); end
        nChecks++; if (init_busy_n !== 1'b0) begin nFails++; $display("FAIL rst_nowin_busy: got %b want 0", init_busy_n); end
        @(posedge clk);
        @(negedge clk);
        nChecks++; if (cyc_cnt_m !== 32'd0) begin nFails++; $display("FAIL rst_cyc_held: got %0d want 0", cyc_cnt_m); end
        // Release with a stall+redirect+forward pattern present during the window.
        rst = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        #1;
        nChecks++; if (init_busy_m !== 1'b1) begin nFails++; $display("FAIL win_busy0: got %b want 1", init_busy_m); end
        nChecks++; if ({StallD_m, ForwardAE_m} !== 3'b000) begin nFails++; $display("FAIL win_gate: got %b want 000", {StallD_m, ForwardAE_m}); end
        nChecks++; if ({StallD_n, ForwardAE_n} !== 3'b110) begin nFails++; $display("FAIL nowin_live: got %b want 110", {StallD_n, ForwardAE_n}); end
        @(posedge clk); #1;
        nChecks++; if (init_busy_m !== 1'b1) begin nFails++; $display("FAIL win_busy1: got %b want 1", init_busy_m); end
        nChecks++; if (cyc_cnt_m !== 32'd1) begin nFails++; $display("FAIL win_cyc1: got %0d want 1", cyc_cnt_m); end
        @(posedge clk); #1;
        nChecks++; if (init_busy_m !== 1'b0) begin nFails++; $display("FAIL win_end_busy: got %b want 0", init_busy_m); end
        nChecks++; if (cyc_cnt_m !== 32'd2) begin nFails++; $display("FAIL win_end_cyc: got %0d want 2", cyc_cnt_m); end
        nChecks++; if ({stall_cnt_m, flush_cnt_m, fwd_cnt_m} !== 96'd0) begin nFails++; $display("FAIL win_end_cnts: got %0d/%0d/%0d want 0/0/0", stall_cnt_m, flush_cnt_m, fwd_cnt_m); end
        nChecks++; if ({StallD_m, FlushD_m, ForwardAE_m} !== 4'b1110) begin nFails++; $display("FAIL post_win_live: got %b want 1110", {StallD_m, FlushD_m, ForwardAE_m}); end
        nChecks++; if (stall_cnt_n !== 32'd2) begin nFails++; $display("FAIL nowin_stall: got %0d want 2", stall_cnt_n); end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_forwarding();
        clearCounters();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        #1;
        nChecks++; if (ForwardAE_m !== 2'b10) begin nFails++; $display("FAIL fwd_mem_prio: got %b want 10", ForwardAE_m); end
        RegWriteM = 1'b0;
        #1;
        nChecks++; if (ForwardAE_m !== 2'b01) begin nFails++; $display("FAIL fwd_wb: got %b want 01", ForwardAE_m); end
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        #1;
        nChecks++; if (ForwardAE_m !== 2'b00) begin nFails++; $display("FAIL fwd_x0: got %b want 00", ForwardAE_m); end
        Rs2E = 5'd9; RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd9; RegWriteW = 1'b1;
        #1;
        nChecks++; if ({ForwardAE_m, ForwardBE_m} !== 4'b0001) begin nFails++; $display("FAIL fwd_b_wb: got %b want 0001", {ForwardAE_m, ForwardBE_m}); end
        @(negedge clk);
        nChecks++; if ({fwd_cnt_m, stall_cnt_m} !== {32'd1, 32'd0}) begin nFails++; $display("FAIL fwd_cnt: got %0d/%0d want 1/0", fwd_cnt_m, stall_cnt_m); end
        setIdle();
    endtask

    task automatic test_load_use();
        clearCounters();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        nChecks++; if ({StallF_m, StallD_m, FlushE_m, FlushD_m} !== 4'b1110) begin nFails++; $display("FAIL lu_ctrl: got %b want 1110", {StallF_m, StallD_m, FlushE_m, FlushD_m}); end
        @(negedge clk);
        // Bubble inserted; the load now sits in MEM.
        ResultSrcE = 2'b00; RdE = 5'd0; Rs2D = 5'd0;
        RdM = 5'd7; RegWriteM = 1'b1; Rs2E = 5'd7;
        #1;
        nChecks++; if ({ForwardBE_m, StallD_m, FlushE_m} !== 4'b1000) begin nFails++; $display("FAIL lu_after: got %b want 1000", {ForwardBE_m, StallD_m, FlushE_m}); end
        nChecks++; if (stall_cnt_m !== 32'd1) begin nFails++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_m); end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_flush_priority();
        clearCounters();
        ResultSrcE = 2'b01; RdE = 5'd12; Rs1D = 5'd12; PCSrcE = 1'b1;
        #1;
        nChecks++; if ({FlushD_m, FlushE_m} !== 2'b11) begin nFails++; $display("FAIL flush_both: got %b want 11", {FlushD_m, FlushE_m}); end
        @(negedge clk);
        setIdle();
        #1;
        nChecks++; if ({FlushD_m, FlushE_m} !== 2'b00) begin nFails++; $display("FAIL flush_one_cycle: got %b want 00", {FlushD_m, FlushE_m}); end
        nChecks++; if ({flush_cnt_m, stall_cnt_m} !== {32'd1, 32'd1}) begin nFails++; $display("FAIL flush_cnts: got %0d/%0d want 1/1", flush_cnt_m, stall_cnt_m); end
    endtask

    task automatic test_saturation();
        clearCounters();
        ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        for (int i = 0; i < 20; i++) @(negedge clk);
        nChecks++; if (stall_cnt_s !== 4'hF) begin nFails++; $display("FAIL sat_stall: got %0d want 15", stall_cnt_s); end
        nChecks++; if (cyc_cnt_s !== 4'hF) begin nFails++; $display("FAIL sat_cyc: got %0d want 15", cyc_cnt_s); end
        nChecks++; if (stall_cnt_m !== 32'd20) begin nFails++; $display("FAIL wide_stall: got %0d want 20", stall_cnt_m); end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        nChecks++; if ({stall_cnt_s, cyc_cnt_s} !== 8'h00) begin nFails++; $display("FAIL sat_clr: got %0d/%0d want 0/0", stall_cnt_s, cyc_cnt_s); end
        @(negedge clk);
        nChecks++; if (stall_cnt_s !== 4'd1) begin nFails++; $display("FAIL sat_resume: got %0d want 1", stall_cnt_s); end
    endtask

    task automatic test_mid_reset();
        // lwStall is still held from the previous scenario.
        rst = 1'b1;
        #1;
        nChecks++; if ({stall_cnt_m, cyc_cnt_m} !== 64'd0) begin nFails++; $display("FAIL mid_rst_cnts: got %0d/%0d want 0/0", stall_cnt_m, cyc_cnt_m); end
        nChecks++; if ({init_busy_m, StallD_m, FlushD_m} !== 3'b101) begin nFails++; $display("FAIL mid_rst_ctrl: got %b want 101", {init_busy_m, StallD_m, FlushD_m}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        nChecks++; if (init_busy_m !== 1'b1) begin nFails++; $display("FAIL mid_win_busy: got %b want 1", init_busy_m); end
        @(posedge clk); #1;
        nChecks++; if ({init_busy_m, StallD_m} !== 2'b01) begin nFails++; $display("FAIL mid_win_end: got %b want 01", {init_busy_m, StallD_m}); end
        nChecks++; if ({cyc_cnt_m, stall_cnt_m} !== {32'd2, 32'd0}) begin nFails++; $display("FAIL mid_win_cnts: got %0d/%0d want 2/0", cyc_cnt_m, stall_cnt_m); end
        @(posedge clk); #1;
        nChecks++; if (stall_cnt_m !== 32'd1) begin nFails++; $display("FAIL mid_stall_resume: got %0d want 1", stall_cnt_m); end
        @(negedge clk);
        setIdle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_flush_priority();
        test_saturation();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
